// File: rtl/osd_cmd_tx.sv
// Transmit end of the 16-bit OSD command channel: serialises requests into held opcode words,
// inserting NOP spacers so consecutive words always differ. Optional macro: OSD_TX_POS_CACHE_EN.
module osd_cmd_tx #(
   parameter int unsigned HOLD_CYCLES = 4,
   parameter logic [15:0] NOP_WORD    = 16'h0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_type,
   input  logic [4:0]  req_x,
   input  logic [4:0]  req_y,
   input  logic [7:0]  req_data,
   input  logic [7:0]  req_attr,
   output logic [15:0] osd_command,
   output logic        busy
);

   typedef enum logic [1:0] {StIdle, StSpace, StEmit} state_e;

   localparam logic [7:0] HoldReload = 8'(HOLD_CYCLES - 1);

   state_e      state_q, state_d;
   // osd_q doubles as the last-word register: both always hold the word on the wire.
   logic [15:0] osd_q, osd_d;
   logic [7:0]  hold_q, hold_d;
   logic [1:0]  idx_q, idx_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [15:0] words_q [4];
   logic [15:0] words_d [4];
   logic [15:0] list_w [4];
   logic [2:0]  list_n;
   logic [15:0] nxt_word;

`ifdef OSD_TX_POS_CACHE_EN
   logic [4:0] x_cache_q, x_cache_d, y_cache_q, y_cache_d;
   logic       x_vld_q, x_vld_d, y_vld_q, y_vld_d;
   logic       skip_x, skip_y;

   assign skip_x = x_vld_q && (req_x == x_cache_q);
   assign skip_y = y_vld_q && (req_y == y_cache_q);
`endif

   // Word list for the request currently presented on req_*.
   always_comb begin
      list_w = '{default: '0};
      list_n = 3'd0;
      unique case (req_type)
         3'd0: begin list_w[0] = {8'h01, 7'b0, req_data[0]}; list_n = 3'd1; end
         3'd1: begin list_w[0] = {8'h02, 7'b0, req_data[0]}; list_n = 3'd1; end
         3'd2: begin
`ifdef OSD_TX_POS_CACHE_EN
            unique case ({skip_x, skip_y})
               2'b00: begin
                  list_w = '{{8'h10, 3'b0, req_x}, {8'h11, 3'b0, req_y},
                             {8'h12, req_data}, {8'h13, req_attr}};
                  list_n = 3'd4;
               end
               2'b01: begin
                  list_w = '{{8'h10, 3'b0, req_x}, {8'h12, req_data}, {8'h13, req_attr}, 16'h0};
                  list_n = 3'd3;
               end
               2'b10: begin
                  list_w = '{{8'h11, 3'b0, req_y}, {8'h12, req_data}, {8'h13, req_attr}, 16'h0};
                  list_n = 3'd3;
               end
               default: begin
                  list_w = '{{8'h12, req_data}, {8'h13, req_attr}, 16'h0, 16'h0};
                  list_n = 3'd2;
               end
            endcase
`else
            list_w = '{{8'h10, 3'b0, req_x}, {8'h11, 3'b0, req_y},
                       {8'h12, req_data}, {8'h13, req_attr}};
            list_n = 3'd4;
`endif
         end
         3'd3: begin list_w[0] = 16'h2001; list_n = 3'd1; end
         3'd4: begin list_w[0] = {8'h21, req_data}; list_n = 3'd1; end
         default: list_n = 3'd0;
      endcase
   end

   assign nxt_word = words_q[idx_q + 2'd1];

   // LOAD and CHECK are folded into the transitions so the first word lands on the accept edge.
   always_comb begin
      state_d = state_q;
      osd_d   = osd_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      words_d = words_q;
      unique case (state_q)
         StIdle: begin
            if (req_valid) begin
               words_d = list_w;
               cnt_d   = list_n;
               idx_d   = 2'd0;
               hold_d  = HoldReload;
               if (list_n != 3'd0) begin
                  if (list_w[0] == osd_q) begin
                     state_d = StSpace;
                     osd_d   = NOP_WORD;
                  end else begin
                     state_d = StEmit;
                     osd_d   = list_w[0];
                  end
               end
            end
         end
         StSpace: begin
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else begin
               hold_d  = HoldReload;
               state_d = StEmit;
               osd_d   = words_q[idx_q];
            end
         end
         StEmit: begin
            if (hold_q != 8'd0) begin
               hold_d = hold_q - 8'd1;
            end else begin
               idx_d  = idx_q + 2'd1;
               hold_d = HoldReload;
               if (({1'b0, idx_q} + 3'd1) < cnt_q) begin
                  if (nxt_word == osd_q) begin
                     state_d = StSpace;
                     osd_d   = NOP_WORD;
                  end else begin
                     state_d = StEmit;
                     osd_d   = nxt_word;
                  end
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef OSD_TX_POS_CACHE_EN
   // A fresh word always differs from osd_q, so a change on osd_d marks an emission.
   always_comb begin
      x_cache_d = x_cache_q;
      y_cache_d = y_cache_q;
      x_vld_d   = x_vld_q;
      y_vld_d   = y_vld_q;
      if (osd_d != osd_q && osd_d[15:8] == 8'h10) begin
         x_cache_d = osd_d[4:0];
         x_vld_d   = 1'b1;
      end
      if (osd_d != osd_q && osd_d[15:8] == 8'h11) begin
         y_cache_d = osd_d[4:0];
         y_vld_d   = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_cache_q <= 5'd0;
         y_cache_q <= 5'd0;
         x_vld_q   <= 1'b0;
         y_vld_q   <= 1'b0;
      end else begin
         x_cache_q <= x_cache_d;
         y_cache_q <= y_cache_d;
         x_vld_q   <= x_vld_d;
         y_vld_q   <= y_vld_d;
      end
   end
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         osd_q   <= NOP_WORD;
         hold_q  <= 8'd0;
         idx_q   <= 2'd0;
         cnt_q   <= 3'd0;
         words_q <= '{default: '0};
      end else begin
         state_q <= state_d;
         osd_q   <= osd_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         words_q <= words_d;
      end
   end

   assign osd_command = osd_q;
   assign req_ready   = (state_q == StIdle);
   assign busy        = (state_q != StIdle);

endmodule

// File: doc/osd_cmd_tx.md
Name: osd_cmd_tx

Overview:
Transmit end of the 16-bit OSD command channel. Accepts high-level OSD requests from the control side over a valid/ready handshake:
- overlay/popup enable
- put character at x,y with attribute
- font loader reset and font byte

Serialises each request into the opcode word sequence the OSD overlay consumes (opcodes 01/02/10/11/12/13/20/21, payload in bits 7:0). The overlay acts only when the word changes, so this block guarantees every emitted word differs from the previous one and holds each word long enough to be sampled.

Parameters:
HOLD_CYCLES, 4, clocks each word (including spacers) is held on osd_command; legal range 1..255.
NOP_WORD, 16'h0000, spacer word inserted between identical consecutive words; opcode 00 is ignored by the overlay.

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_type  in  3  0=OVERLAY, 1=POPUP, 2=PUT_CHAR, 3=FONT_RESET, 4=FONT_BYTE, 5..7 reserved
req_x  in  5  column 0..31 (PUT_CHAR)
req_y  in  5  row 0..31 (PUT_CHAR)
req_data  in  8  enable bit in [0] (OVERLAY/POPUP), character code (PUT_CHAR), font byte (FONT_BYTE)
req_attr  in  8  attribute byte (PUT_CHAR)
osd_command  out  16  command word to the overlay
busy  out  1  sequence in progress (inverse of req_ready)

Behaviour:
- Reset values: osd_command=NOP_WORD, req_ready=1, busy=0. Last-word register=NOP_WORD. Hold counter=0. State=IDLE.
- Reset asserted mid-sequence aborts it immediately. Remaining words are never sent.
- Handshake: a request is accepted on a rising edge with req_valid&&req_ready. All req_* fields are latched on that edge. req_ready is high only in IDLE.
- Word lists per type:
  - OVERLAY: {8'h01, 7'b0, data[0]}
  - POPUP: {8'h02, 7'b0, data[0]}
  - PUT_CHAR: {8'h10, 3'b0, x}, {8'h11, 3'b0, y}, {8'h12, char}, {8'h13, attr}
  - FONT_RESET: 16'h2001
  - FONT_BYTE: {8'h21, data}
  - Reserved types: accepted, no words emitted, return to IDLE next cycle.
- FSM: IDLE -> LOAD (build list, set index=0) -> CHECK -> SPACE or EMIT -> CHECK ... -> IDLE.
  - CHECK: if the next word equals the last-word register, go to SPACE; else go to EMIT.
  - SPACE: drive NOP_WORD for HOLD_CYCLES clocks and set last-word=NOP_WORD, then go to EMIT.
  - EMIT: drive the word for HOLD_CYCLES clocks, update last-word, increment index. Go to CHECK if words remain, else IDLE.
  - CHECK and LOAD are combinational-decision states folded so that no extra dead clocks appear. The first word is on osd_command on the clock edge after acceptance (latency 1), or a spacer is there instead.
- osd_command is registered and changes only at word boundaries. It keeps the last word after the sequence ends, with no return to NOP.
- Sequence length in clocks = (words + spacers) * HOLD_CYCLES. req_ready rises on the edge that ends the last hold.
- Consecutive FONT_BYTE requests with equal data therefore produce 21xx, 0000, 21xx.
- FONT_RESET after FONT_RESET produces 2001, 0000, 2001.
- After reset, a first OVERLAY with data[0]=0 emits 0100, which differs from 0000, so no spacer is inserted.
- Index width is 2 bits (max 4 words). The hold counter is 8 bits and reloads with HOLD_CYCLES-1.

Optional Feature:
- Macro: OSD_TX_POS_CACHE_EN.
- When defined, the block keeps x_cache/y_cache with valid flags. PUT_CHAR omits the 10 word if x equals the valid x_cache, and omits the 11 word if y equals the valid y_cache. This is safe because the overlay retains its write-address registers.
- The caches update when their word is emitted. Reset clears the valid flags.
- Spacer rules apply to the reduced list.
- When undefined, PUT_CHAR always emits all four words.

Test Plan:
- Reset, then OVERLAY data=1, HOLD_CYCLES=4 -> osd_command=16'h0101 on edge after accept; req_ready high again 4 clocks later; no spacer.
- PUT_CHAR x=3 y=5 char=8'h41 attr=8'h70 -> words 1003, 1105, 1241, 1370, each held 4 clocks; busy for 16 clocks.
- FONT_RESET, then FONT_BYTE 8'hAA twice -> 2001, 21AA, 0000, 21AA; spacer held exactly HOLD_CYCLES.
- reset_n pulled low during the 2nd word of PUT_CHAR -> osd_command=0000 asynchronously, req_ready=1; after release a new request sequences normally.
- req_type=6 -> accepted, osd_command unchanged, req_ready back high next cycle.
- With OSD_TX_POS_CACHE_EN: PUT_CHAR (3,5), then PUT_CHAR (4,5) -> second sequence is 1004, 1242, 13xx (11 word skipped); without the macro, all four words are emitted.
